// File: rtl/matseq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matseq_pkg                                                 |
// | Description : Shared types and constants for matrix_op_sequencer:        |
// |               FSM state encoding, opcode, error words, header indices.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// MEM_SIZE normally arrives from the project constants include; this fallback
// only applies when that include has not already defined it.
`ifndef MEM_SIZE
`define MEM_SIZE 3
`endif

package matseq_pkg;

    typedef enum logic [2:0] {
        HDR    = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        DRAIN  = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Side length of the square operand/result arrays
    localparam int c_MAX_DIM = `MEM_SIZE + 1;

    localparam logic [31:0] c_OPC_MATMUL  = 32'd1;

    localparam logic [31:0] c_ERR_OPCODE  = 32'hE000_0001;
    localparam logic [31:0] c_ERR_DIM     = 32'hE000_0002;
    localparam logic [31:0] c_ERR_TIMEOUT = 32'hE000_0003;

    // operation_reg word indices
    localparam int c_HDR_OPC = 0;  // opcode
    localparam int c_HDR_R   = 1;  // rows of A / C
    localparam int c_HDR_K   = 2;  // inner dimension
    localparam int c_HDR_K2  = 3;  // inner dimension repeated, must match
    localparam int c_HDR_CC  = 4;  // columns of B / C
    localparam int c_OP_RUN  = 5;  // engine run flag
    localparam int c_OP_RSVD = 6;  // reserved, always zero

    // A dimension is legal when it lies in 1..max_dim
    function automatic logic dim_ok(input logic [31:0] d, input int unsigned max_dim);
        return (d != 32'd0) && (d <= max_dim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matseq_out_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matseq_out_stage                                           |
// | Description : One-deep registered valid/ready holding stage. A word is   |
// |               loaded only while the stage is free, so data and last stay |
// |               stable for as long as the consumer stalls.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module matseq_out_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_last,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_free
);

    logic        r_valid;
    logic [31:0] r_data;
    logic        r_last;

    // Free when empty or when the held word leaves this cycle
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    // Capture a new word when loaded, otherwise empty out on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_op_sequencer                                        |
// | Description : Host-side initiator for the matrix multiply engine. Parses |
// |               a 5-word header, loads A and B row-major, starts the       |
// |               engine, waits for a fresh done and streams C row-major.    |
// |               Optional macro MATSEQ_TIMEOUT_EN adds a WAIT watchdog that |
// |               reports 0xE000_0003 after TIMEOUT_CYCLES.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module matrix_op_sequencer
    import matseq_pkg::*;
#(
    parameter int MAX_DIM        = c_MAX_DIM,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        mm_enable,
    input  logic        mm_done,
    output logic [31:0] operation_reg [0:6],
    output logic [31:0] matrixA_out [MAX_DIM][MAX_DIM],
    output logic [31:0] matrixB_out [MAX_DIM][MAX_DIM],
    input  logic [31:0] matrixC_in  [MAX_DIM][MAX_DIM]
);

    localparam int c_IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    state_t            r_state;
    logic [2:0]        r_hdr_cnt;
    logic [c_IW-1:0]   r_row;
    logic [c_IW-1:0]   r_col;
    logic [31:0]       r_op [0:5];
    logic [31:0]       r_a  [MAX_DIM][MAX_DIM];
    logic [31:0]       r_b  [MAX_DIM][MAX_DIM];
    logic              r_mm_enable;
    logic              r_armed;     // engine done seen low since START
    logic              r_issued;    // final word of the response handed to the stage
    logic [31:0]       r_err_code;

    logic              w_in_fire;
    logic              w_out_done;
    logic              w_free;
    logic              w_load;
    logic [31:0]       w_load_data;
    logic              w_load_last;
    logic [31:0]       w_rows;
    logic [31:0]       w_cols;
    logic              w_row_last;
    logic              w_col_last;

`ifdef MATSEQ_TIMEOUT_EN
    logic [31:0]       r_tmo_cnt;
    logic              w_tmo_hit;
    assign w_tmo_hit = (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic              w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    assign in_ready   = !reset && ((r_state == HDR) || (r_state == LOAD_A) || (r_state == LOAD_B));
    assign busy       = (r_state != HDR);
    assign mm_enable  = r_mm_enable;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_done = out_valid && out_ready && out_last;

    assign matrixA_out = r_a;
    assign matrixB_out = r_b;

    // Expose the operation registers; the reserved word is tied low
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            operation_reg[i] = r_op[i];
        end
        operation_reg[c_OP_RSVD] = '0;
    end

    // Row/column limits of the array currently being walked
    always_comb begin
        w_rows = r_op[c_HDR_R];
        w_cols = r_op[c_HDR_CC];
        case (r_state)
            LOAD_A:  begin w_rows = r_op[c_HDR_R]; w_cols = r_op[c_HDR_K];  end
            LOAD_B:  begin w_rows = r_op[c_HDR_K]; w_cols = r_op[c_HDR_CC]; end
            default: begin w_rows = r_op[c_HDR_R]; w_cols = r_op[c_HDR_CC]; end
        endcase
        w_row_last = (32'(r_row) == w_rows - 32'd1);
        w_col_last = (32'(r_col) == w_cols - 32'd1);
    end

    // Feed the output stage: C elements in DRAIN, the error word in ERR
    always_comb begin
        w_load      = ((r_state == DRAIN) || (r_state == ERR)) && !r_issued && w_free;
        w_load_data = (r_state == ERR) ? r_err_code : matrixC_in[r_row][r_col];
        w_load_last = (r_state == ERR) ? 1'b1 : (w_row_last && w_col_last);
    end

    matseq_out_stage u_out_stage (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_free  (w_free)
    );

    // Command sequencer: header parse, operand load, engine handshake, drain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HDR;
            r_hdr_cnt   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_mm_enable <= 1'b0;
            r_armed     <= 1'b0;
            r_issued    <= 1'b0;
            r_err_code  <= '0;
            for (int i = 0; i < 6; i++) r_op[i] <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
            end
`ifdef MATSEQ_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                HDR: begin
                    if (w_in_fire) begin
                        if (r_hdr_cnt == 3'(c_HDR_CC)) begin
                            r_op[c_HDR_CC] <= in_data;
                            r_hdr_cnt      <= '0;
                            r_issued       <= 1'b0;
                            if (r_op[c_HDR_OPC] != c_OPC_MATMUL) begin
                                r_err_code <= c_ERR_OPCODE;
                                r_state    <= ERR;
                            end else if (!dim_ok(r_op[c_HDR_R], MAX_DIM) ||
                                         !dim_ok(r_op[c_HDR_K], MAX_DIM) ||
                                         !dim_ok(in_data, MAX_DIM) ||
                                         (r_op[c_HDR_K2] != r_op[c_HDR_K])) begin
                                r_err_code <= c_ERR_DIM;
                                r_state    <= ERR;
                            end else begin
                                // Unused rows/columns must read as zero to the engine
                                for (int i = 0; i < MAX_DIM; i++) begin
                                    for (int j = 0; j < MAX_DIM; j++) begin
                                        r_a[i][j] <= '0;
                                        r_b[i][j] <= '0;
                                    end
                                end
                                r_row   <= '0;
                                r_col   <= '0;
                                r_state <= LOAD_A;
                            end
                        end else begin
                            r_op[r_hdr_cnt] <= in_data;
                            r_hdr_cnt       <= r_hdr_cnt + 3'd1;
                        end
                    end
                end

                LOAD_A, LOAD_B: begin
                    if (w_in_fire) begin
                        if (r_state == LOAD_A) r_a[r_row][r_col] <= in_data;
                        else                   r_b[r_row][r_col] <= in_data;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= (r_state == LOAD_A) ? LOAD_B : START;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                START: begin
                    r_op[c_OP_RUN] <= 32'd1;
                    r_mm_enable    <= 1'b1;
                    r_armed        <= 1'b0;
                    r_state        <= WAIT;
`ifdef MATSEQ_TIMEOUT_EN
                    r_tmo_cnt      <= '0;
`endif
                end

                WAIT: begin
`ifdef MATSEQ_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
`endif
                    // A done that was already high at START is stale; only a
                    // low-then-high sequence counts as completion.
                    if (r_armed && mm_done) begin
                        r_mm_enable    <= 1'b0;
                        r_op[c_OP_RUN] <= 32'd0;
                        r_row          <= '0;
                        r_col          <= '0;
                        r_issued       <= 1'b0;
                        r_state        <= DRAIN;
                    end
`ifdef MATSEQ_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_mm_enable    <= 1'b0;
                        r_op[c_OP_RUN] <= 32'd0;
                        r_err_code     <= c_ERR_TIMEOUT;
                        r_issued       <= 1'b0;
                        r_state        <= ERR;
                    end
`endif
                    else if (!mm_done) begin
                        r_armed <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (w_load) begin
                        if (w_row_last && w_col_last) begin
                            r_issued <= 1'b1;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    if (w_out_done) r_state <= HDR;
                end

                ERR: begin
                    if (w_load)     r_issued <= 1'b1;
                    if (w_out_done) r_state  <= HDR;
                end

                default: r_state <= HDR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_matrix_op_sequencer                                     |
// | Description : Directed and randomized bench for matrix_op_sequencer with |
// |               an engine model and a plain-arithmetic matrix product as   |
// |               the reference for every result word.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_matrix_op_sequencer;
    import matseq_pkg::*;

    localparam int MD = c_MAX_DIM;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        mm_enable;
    logic        mm_done;
    logic [31:0] op_reg [0:6];
    logic [31:0] mat_a  [MD][MD];
    logic [31:0] mat_b  [MD][MD];
    logic [31:0] mat_c  [MD][MD];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit gaps      = 1'b0;  // insert random in_valid gaps
    int rmode     = 0;     // 0 always ready, 1 toggle, 2 random
    bit eng_stuck = 1'b0;  // engine never completes

    logic [31:0] ma [MD][MD];
    logic [31:0] mb [MD][MD];
    logic [31:0] expq [$];

    always #5 clk = ~clk;

    matrix_op_sequencer u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .mm_enable     (mm_enable),
        .mm_done       (mm_done),
        .operation_reg (op_reg),
        .matrixA_out   (mat_a),
        .matrixB_out   (mat_b),
        .matrixC_in    (mat_c)
    );

    // Engine model: on enable keeps a stale done briefly, poisons C, then
    // multiplies the full square arrays and raises done until enable drops.
    initial begin
        logic [31:0] s;
        mm_done = 1'b0;
        for (int i = 0; i < MD; i++) for (int j = 0; j < MD; j++) mat_c[i][j] = '0;
        forever begin
            @(negedge clk);
            if (eng_stuck) begin
                mm_done = 1'b0;
            end else if (mm_enable === 1'b1 && reset === 1'b0) begin
                for (int i = 0; i < MD; i++) for (int j = 0; j < MD; j++) mat_c[i][j] = 32'hDEAD_BEEF;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                mm_done = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                for (int i = 0; i < MD; i++) begin
                    for (int j = 0; j < MD; j++) begin
                        s = '0;
                        for (int t = 0; t < MD; t++) s = s + mat_a[i][t] * mat_b[t][j];
                        mat_c[i][j] = s;
                    end
                end
                mm_done = 1'b1;
                while (mm_enable === 1'b1) @(negedge clk);
            end
        end
    end

    // Global time limit
    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, observed running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until the DUT shows ready at a negedge
    task automatic send_word(input logic [31:0] w);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input int opc, input int r, input int k, input int k2, input int c);
        send_word(32'(opc));
        send_word(32'(r));
        send_word(32'(k));
        send_word(32'(k2));
        send_word(32'(c));
    endtask

    // Receive expq in order, checking last flags, stall stability and no extras
    task automatic collect(input string tag);
        int          got;
        int          n;
        bit          held;
        bit          extra;
        logic [31:0] hd;
        logic        hl;
        got = 0; n = 0; held = 1'b0; hd = '0; hl = 1'b0;
        while (got < expq.size() && n < 4000) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (held) begin
                check($sformatf("%s_stall_valid", tag), {31'd0, out_valid}, 32'd1);
                check($sformatf("%s_stall_data", tag), out_data, hd);
                check($sformatf("%s_stall_last", tag), {31'd0, out_last}, {31'd0, hl});
            end
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    check($sformatf("%s_data%0d", tag, got), out_data, expq[got]);
                    check($sformatf("%s_last%0d", tag, got), {31'd0, out_last},
                          (got == expq.size() - 1) ? 32'd1 : 32'd0);
                    got++;
                end else begin
                    held = 1'b1;
                    hd   = out_data;
                    hl   = out_last;
                end
            end
            @(negedge clk);
            n++;
        end
        if (got < expq.size()) check($sformatf("%s_words_timeout", tag), 32'(got), 32'(expq.size()));
        out_ready = 1'b1;
        extra = 1'b0;
        repeat (4) begin
            if (out_valid === 1'b1) extra = 1'b1;
            @(negedge clk);
        end
        check($sformatf("%s_no_extra", tag), {31'd0, extra}, 32'd0);
        check($sformatf("%s_in_ready_after", tag), {31'd0, in_ready}, 32'd1);
        check($sformatf("%s_idle_after", tag), {31'd0, busy}, 32'd0);
    endtask

    // Full command using ma/mb; expected C is the plain matrix product
    task automatic do_cmd(input int r, input int k, input int c, input string tag);
        logic [31:0] s;
        send_hdr(1, r, k, k, c);
        check($sformatf("%s_busy_load", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s_op_rows", tag), op_reg[1], 32'(r));
        check($sformatf("%s_op6", tag), op_reg[6], 32'd0);
        for (int i = 0; i < r; i++) for (int j = 0; j < k; j++) send_word(ma[i][j]);
        for (int i = 0; i < k; i++) for (int j = 0; j < c; j++) send_word(mb[i][j]);
        expq.delete();
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                s = '0;
                for (int t = 0; t < k; t++) s = s + ma[i][t] * mb[t][j];
                expq.push_back(s);
            end
        end
        collect(tag);
    endtask

    task automatic rand_mats();
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                ma[i][j] = $urandom;
                mb[i][j] = $urandom;
            end
        end
    endtask

    task automatic expect_err(input logic [31:0] code, input string tag);
        expq.delete();
        expq.push_back(code);
        collect(tag);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mm_enable", {31'd0, mm_enable}, 32'd0);
        for (int i = 0; i < 7; i++) check($sformatf("rst_op%0d", i), op_reg[i], 32'd0);
        check("rst_a00", mat_a[0][0], 32'd0);
        check("rst_bnn", mat_b[MD-1][MD-1], 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("hdr_in_ready", {31'd0, in_ready}, 32'd1);

        // 2x2x2 known product
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        do_cmd(2, 2, 2, "mm2x2");

        // 1x3 times 3x1
        ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3;
        mb[0][0] = 4; mb[1][0] = 5; mb[2][0] = 6;
        do_cmd(1, 3, 1, "dot3");

        // Bad opcode, then a valid 1x1x1
        send_hdr(7, 1, 1, 1, 1);
        expect_err(32'hE000_0001, "err_opc");
        ma[0][0] = 3; mb[0][0] = 4;
        do_cmd(1, 1, 1, "after_err");

        // Illegal dimensions
        send_hdr(1, 2, 2, 3, 2);
        expect_err(32'hE000_0002, "err_kmis");
        send_hdr(1, 0, 1, 1, 1);
        expect_err(32'hE000_0002, "err_r0");
        send_hdr(1, MD + 1, 1, 1, 1);
        expect_err(32'hE000_0002, "err_rbig");
        send_hdr(1, 1, 1, 1, MD + 1);
        expect_err(32'hE000_0002, "err_cbig");
        send_hdr(1, 1, 0, 0, 1);
        expect_err(32'hE000_0002, "err_k0");

        // Largest legal size
        rand_mats();
        do_cmd(MD, MD, MD, "mm_max");

        // 3x3 with input gaps and toggling out_ready
        gaps  = 1'b1;
        rmode = 1;
        rand_mats();
        do_cmd(3, 3, 3, "mm3x3_stall");

        // Random shapes, random backpressure
        rmode = 2;
        for (int it = 0; it < 4; it++) begin
            rand_mats();
            do_cmd($urandom_range(1, MD), $urandom_range(1, MD), $urandom_range(1, MD),
                   $sformatf("rnd%0d", it));
        end
        gaps  = 1'b0;
        rmode = 0;

        // Reset while waiting on a stuck engine
        eng_stuck = 1'b1;
        rand_mats();
        send_hdr(1, 2, 2, 2, 2);
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) send_word(ma[i][j]);
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) send_word(mb[i][j]);
        n = 0;
        while (mm_enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        check("wait_enable", {31'd0, mm_enable}, 32'd1);
        check("wait_run_flag", op_reg[5], 32'd1);
        check("wait_no_output", {31'd0, out_valid}, 32'd0);
        check("wait_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rst_mid_enable", {31'd0, mm_enable}, 32'd0);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_run_flag", op_reg[5], 32'd0);
        check("rst_mid_op1", op_reg[1], 32'd0);
        check("rst_mid_a00", mat_a[0][0], 32'd0);
        reset     = 1'b0;
        eng_stuck = 1'b0;
        @(negedge clk);
        rand_mats();
        do_cmd(2, 2, 2, "after_rst");

`ifdef MATSEQ_TIMEOUT_EN
        // Engine never completes: timeout error after the watchdog window
        eng_stuck = 1'b1;
        send_hdr(1, 1, 1, 1, 1);
        send_word(32'd2);
        send_word(32'd3);
        n = 0;
        while (mm_enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (out_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        check("tmo_latency_window", {31'd0, (n >= 4090 && n <= 4110)}, 32'd1);
        check("tmo_enable_dropped", {31'd0, mm_enable}, 32'd0);
        check("tmo_run_flag", op_reg[5], 32'd0);
        expect_err(32'hE000_0003, "err_tmo");
        eng_stuck = 1'b0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
